// File: rtl/fifo_read_serializer_pkg.sv
// Shared types and helpers for the FIFO read-side word-to-beat serializer.
// Holds the two-state load flag encoding and the beat-index width calculation.
package fifo_read_serializer_pkg;

    typedef enum logic [0:0] {
        EMPTY  = 1'b0,
        LOADED = 1'b1
    } state_t;

    function automatic int beat_idx_w(input int ratio);
        return $clog2(ratio);
    endfunction

endpackage

// File: rtl/fifo_read_serializer.sv
// Pops FWFT FIFO words and emits RATIO beats LSB-chunk first; 1 cycle fill latency, 1 beat/cycle steady.
// Holds beat and defers the next pop while out_ready=0; out_last exists only with FIFO_READ_SERIALIZER_LAST_EN.
module fifo_read_serializer
    import fifo_read_serializer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RATIO = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     fifo_empty,
    output logic                     fifo_read_enable,
    input  logic [WIDTH-1:0]         fifo_read_data,
    output logic                     out_valid,
    input  logic                     out_ready,
`ifdef FIFO_READ_SERIALIZER_LAST_EN
    output logic                     out_last,
`endif
    output logic [WIDTH/RATIO-1:0]   out_data
);

    localparam int BEAT_WIDTH = WIDTH / RATIO;
    localparam int CW         = beat_idx_w(RATIO);
    localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

    if (RATIO < 2) begin : g_bad_ratio
        $error("fifo_read_serializer: RATIO must be at least 2");
    end
    if (WIDTH % RATIO != 0) begin : g_bad_width
        $error("fifo_read_serializer: WIDTH must be a multiple of RATIO");
    end

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_word_buffer;

    logic w_loaded;
    logic w_accept;
    logic w_final_beat;
    logic w_pop;

    assign w_loaded     = (r_state == LOADED);
    assign w_accept     = w_loaded && out_ready;
    assign w_final_beat = (r_count == LAST_IDX);

    // Reload on the same edge as the final beat so consecutive words run without a bubble.
    assign w_pop = !reset && !fifo_empty && (!w_loaded || (w_accept && w_final_beat));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= EMPTY;
            r_count       <= '0;
            r_word_buffer <= '0;
        end else if (w_pop) begin
            r_state       <= LOADED;
            r_count       <= '0;
            r_word_buffer <= fifo_read_data;
        end else if (w_accept) begin
            if (w_final_beat) begin
                r_state <= EMPTY;
                r_count <= '0;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    assign fifo_read_enable = w_pop;
    assign out_valid        = w_loaded;
    assign out_data         = r_word_buffer[r_count*BEAT_WIDTH +: BEAT_WIDTH];

`ifdef FIFO_READ_SERIALIZER_LAST_EN
    assign out_last = w_loaded && w_final_beat;
`endif

endmodule

// File: tb/tb_fifo_read_serializer.sv
// Directed + random bench for fifo_read_serializer against a FIFO queue and a beat-queue scoreboard.
module tb_fifo_read_serializer;

    logic        clock = 1'b0;
    logic        reset;
    logic        fifo_empty;
    logic        fifo_read_enable;
    logic [31:0] fifo_read_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
`ifdef FIFO_READ_SERIALIZER_LAST_EN
    logic        out_last;
`endif

    fifo_read_serializer #(.WIDTH(32), .RATIO(4)) dut (
        .clock            (clock),
        .reset            (reset),
        .fifo_empty       (fifo_empty),
        .fifo_read_enable (fifo_read_enable),
        .fifo_read_data   (fifo_read_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
`ifdef FIFO_READ_SERIALIZER_LAST_EN
        .out_last         (out_last),
`endif
        .out_data         (out_data)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int pops     = 0;
    int beats    = 0;

    logic [31:0] fq[$];   // contents of the upstream FIFO
    logic [7:0]  bq[$];   // beats still owed by the DUT, in order

    logic last_pop;
    logic last_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called shortly after a rising edge; drives inputs, checks at the falling edge,
    // then advances the reference model across the next rising edge.
    task automatic cycle(input bit rdy);
        logic exp_valid;
        logic exp_pop;
        logic [31:0] w;
        out_ready      = rdy;
        fifo_empty     = (fq.size() == 0);
        fifo_read_data = (fq.size() != 0) ? fq[0] : $urandom;
        @(negedge clock);
        exp_valid = (bq.size() > 0);
        exp_pop   = !fifo_empty && (bq.size() == 0 || (bq.size() == 1 && rdy));
        last_pop   = fifo_read_enable;
        last_valid = out_valid;
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
        chk("fifo_read_enable", {31'd0, fifo_read_enable}, {31'd0, exp_pop});
        if (exp_valid) chk("out_data", {24'd0, out_data}, {24'd0, bq[0]});
`ifdef FIFO_READ_SERIALIZER_LAST_EN
        chk("out_last", {31'd0, out_last}, {31'd0, (bq.size() == 1)});
`endif
        @(posedge clock);
        if (exp_valid && rdy) begin
            void'(bq.pop_front());
            beats++;
        end
        if (exp_pop) begin
            w = fq.pop_front();
            for (int i = 0; i < 4; i++) bq.push_back(w[8*i +: 8]);
            pops++;
        end
        #1;
    endtask

    task automatic drain(input int budget, input bit random_ready);
        int n = 0;
        while ((fq.size() != 0 || bq.size() != 0) && n < budget) begin
            cycle(random_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        chk("drain_done", {31'd0, (fq.size() == 0 && bq.size() == 0)}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int b0;
        reset          = 1'b1;
        fifo_empty     = 1'b1;
        fifo_read_data = 32'h0;
        out_ready      = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_pop", {31'd0, fifo_read_enable}, 32'd0);
`ifdef FIFO_READ_SERIALIZER_LAST_EN
        chk("rst_last", {31'd0, out_last}, 32'd0);
`endif
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Idle with an empty FIFO.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1);
            chk("idle_data", {24'd0, out_data}, 32'd0);
        end

        // Single word.
        fq.push_back(32'hDDCCBBAA);
        p0 = pops;
        for (int i = 0; i < 6; i++) cycle(1'b1);
        chk("single_pops", pops - p0, 32'd1);
        chk("single_beats", {31'd0, (bq.size() == 0)}, 32'd1);

        // Back-to-back stream of 25 words: 1 fill cycle then 100 gapless beats.
        for (int k = 0; k < 25; k++)
            fq.push_back({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
        p0 = pops;
        b0 = beats;
        for (int i = 0; i < 101; i++) begin
            cycle(1'b1);
            if (i > 1 && i < 101) chk("stream_nogap", {31'd0, last_valid}, 32'd1);
        end
        chk("stream_pops", pops - p0, 32'd25);
        chk("stream_beats", beats - b0, 32'd100);
        cycle(1'b1);
        chk("stream_end_valid", {31'd0, last_valid}, 32'd0);

        // Random words under 50% backpressure.
        for (int k = 0; k < 20; k++) fq.push_back($urandom);
        p0 = pops;
        drain(1000, 1'b1);
        chk("bp_pops", pops - p0, 32'd20);

        // Reset mid-word: the rest of the first word is dropped.
        fq.push_back(32'h44332211);
        fq.push_back(32'h88776655);
        cycle(1'b1);
        cycle(1'b1);
        cycle(1'b1);
        chk("mid_beats_left", bq.size(), 32'd2);
        fifo_empty     = 1'b0;
        fifo_read_data = fq[0];
        reset          = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_data", {24'd0, out_data}, 32'd0);
        chk("midrst_pop", {31'd0, fifo_read_enable}, 32'd0);
        bq.delete();
        @(posedge clock);
        #1;
        chk("midrst_pop_hold", {31'd0, fifo_read_enable}, 32'd0);
        reset = 1'b0;
        p0 = pops;
        drain(50, 1'b0);
        chk("midrst_pops", pops - p0, 32'd1);

        // Refill exactly on the final-beat cycle.
        fq.push_back(32'hA3A2A1A0);
        for (int i = 0; i < 4; i++) cycle(1'b1);
        chk("refill_pending", bq.size(), 32'd1);
        fq.push_back(32'hB3B2B1B0);
        cycle(1'b1);
        chk("refill_pop", {31'd0, last_pop}, 32'd1);
        cycle(1'b1);
        chk("refill_nobubble", {31'd0, last_valid}, 32'd1);
        drain(20, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
